vec_csr_unit: RTL and testbench
===============================

// Module: vec_csr_unit
// PURPOSE
//  Parametrised vector CSR file and vsetvl engine; the next generation of the scalar-CSR vl/vq registers.
//  Holds vstart, vxsat, vxrm, vcsr, vl, vtype and vlenb.
//  Sits beside the machine CSR block in ID/EX and serves Zicsr reads and writes.
//  Resolves vsetvli/vsetivli/vsetvl through a 3-state FSM and drives vl/vtype into the vector datapath.
// PARAMETERS
//  XLEN    32   scalar data width
//  VLEN    256  vector register length in bits (power of 2)
//  ELEN    32   maximum supported SEW in bits
//  VL_W    $clog2(VLEN)+1  width of vl and vstart (9 at VLEN=256)
//  RST_VL  8    vl value after reset
// PORTS
//  clk           in   1     core clock
//  rst           in   1     asynchronous reset, active high
//  csr_adr_wr    in   12    CSR write address
//  csr_wrdata    in   XLEN  CSR write data
//  csr_wr_en     in   1     CSR write strobe
//  csr_adr_rd    in   12    CSR read address
//  csr_rddata    out  XLEN  registered read data
//  freeze        in   1     pipeline stall: holds csr_rddata and the FSM
//  vset_req      in   1     one-cycle vsetvl request pulse
//  vset_avl      in   XLEN  requested AVL (rs1 value or uimm)
//  vset_vtype    in   XLEN  requested vtype
//  vset_mode     in   2     00 use AVL, 01 AVL=max (rs1=x0,rd!=x0), 10 keep vl (rs1=rd=x0)
//  vset_busy     out  1     FSM not in IDLE
//  vset_ack      out  1     one-cycle pulse; vset_vl is valid in this cycle
//  vset_vl       out  VL_W  new vl, written to rd by the pipeline
//  vxsat_set     in   1     saturation event from the vector ALU
//  vec_trap      in   1     vector instruction trapped mid-stream
//  vec_trap_idx  in   VL_W  element index of the trap
//  vec_done      in   1     vector instruction completed
//  vl            out  VL_W  current vl
//  vsew          out  3     vtype.vsew
//  vlmul         out  3     vtype.vlmul
//  vta           out  1     vtype.vta
//  vma           out  1     vtype.vma
//  vill          out  1     vtype.vill
//  vstart        out  VL_W  current vstart
//  vxrm          out  2     rounding mode
// BEHAVIOUR
//  CSR addresses: vstart 0x008, vxsat 0x009, vxrm 0x00A, vcsr 0x00F, vl 0xC20, vtype 0xC21, vlenb 0xC22.
//  Reset values: vl=RST_VL; vtype={vill=0,vma=0,vta=0,vsew=010,vlmul=000}; vstart=0; vxsat=0; vxrm=2'b11; csr_rddata=0; ack=busy=0; FSM=IDLE.
//  Read path: csr_rddata registered 1 cycle after csr_adr_rd; held while freeze=1; unmapped addresses read 0.
//   vtype reads as {vill,XLEN-9 zeros,vma,vta,vsew,vlmul}. vlenb reads as constant VLEN/8. vcsr reads as {vxrm,vxsat}.
//  Write path:
//   vl, vtype, vlenb are read-only; writes to them are ignored.
//   vstart takes wrdata[VL_W-1:0]. vxrm takes [1:0]. vxsat takes [0]. vcsr takes [2:1] into vxrm and [0] into vxsat.
//  vxsat next = (CSR write ? wrdata bit : vxsat) | vxsat_set. A set event in the same cycle as a write of 0 leaves vxsat=1.
//  vstart priority: vsetvl ack (clear to 0) > vec_trap (load vec_trap_idx) > vec_done (clear) > CSR write.
//  FSM states and transitions:
//   IDLE: vset_req && !freeze -> DECODE. Latches avl, vtype and mode. vset_req is ignored outside IDLE.
//   DECODE: computes VLMAX = (VLEN>>(3+vsew)) shifted left by vlmul[1:0] (integer LMUL) or right by 8-vlmul (fractional LMUL).
//     vill = vsew>3 | (8<<vsew)>ELEN | vlmul==100 | VLMAX==0 | vtype[XLEN-2:8]!=0. Goes to COMMIT.
//   COMMIT: new_vl = vill ? 0 : mode01 ? VLMAX : mode10 ? min(vl,VLMAX) : min(avl,VLMAX).
//     avl is compared at full XLEN with no truncation before the min.
//     Updates vl and vtype (if vill: vtype={vill=1, rest 0}); pulses vset_ack; clears vstart; -> IDLE.
//  Latency: vset_ack rises 2 cycles after the accepted vset_req; vl is visible on the next cycle. freeze stalls the FSM in place.
//  rst asserted mid-FSM returns to IDLE with reset values and no ack.
// CONFIGURATION
//  VCSR_PERF_CNT_EN defined: 32-bit read-only counter at 0xCC0, counts vec_done pulses; reset 0; wraps at 2^32.
//  VCSR_PERF_CNT_EN undefined: no counter logic; 0xCC0 reads 0.
// TESTING
//  Reset, then read 0xC20 / 0xC21 / 0xC22 -> 8 / 0x10 / 32.
//  vset vtype=0x10 (e32,m1), avl=100, mode00 -> ack 2 cycles later, vset_vl=8.
//    vtype=0x03 (e8,m8), mode01 -> vl=256.
//  vtype=0x18 (e64, ELEN=32) -> vill=1, vl=0, vtype read 0x80000000. vlmul=100 -> same result.
//  vxsat_set in the same cycle as a vcsr write of 0x4 -> vxrm=2, vxsat=1.
//  vec_trap idx=5 -> vstart=5. A following vset ack -> vstart=0.
//  freeze high for 3 cycles during DECODE -> ack delayed 3 cycles. rst in COMMIT -> no ack, vl=8.

Source files
------------

// File: rtl/vec_csr_unit.sv
// Vector CSR file (vstart/vxsat/vxrm/vcsr/vl/vtype/vlenb) with a vsetvl resolution FSM.
// Optional VCSR_PERF_CNT_EN adds a read-only vec_done counter at 0xCC0.
//
// state  | meaning
// IDLE   | waiting for vset_req; request fields latched on acceptance
// DECODE | VLMAX and vill computed from the latched vtype
// COMMIT | vl/vtype updated, vset_ack pulsed, vstart cleared
module vec_csr_unit #(
  parameter int XLEN   = 32,
  parameter int VLEN   = 256,
  parameter int ELEN   = 32,
  parameter int VL_W   = $clog2(VLEN) + 1,
  parameter int RST_VL = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_adr_wr,
  input  logic [XLEN-1:0] csr_wrdata,
  input  logic            csr_wr_en,
  input  logic [11:0]     csr_adr_rd,
  output logic [XLEN-1:0] csr_rddata,
  input  logic            freeze,
  input  logic            vset_req,
  input  logic [XLEN-1:0] vset_avl,
  input  logic [XLEN-1:0] vset_vtype,
  input  logic [1:0]      vset_mode,
  output logic            vset_busy,
  output logic            vset_ack,
  output logic [VL_W-1:0] vset_vl,
  input  logic            vxsat_set,
  input  logic            vec_trap,
  input  logic [VL_W-1:0] vec_trap_idx,
  input  logic            vec_done,
  output logic [VL_W-1:0] vl,
  output logic [2:0]      vsew,
  output logic [2:0]      vlmul,
  output logic            vta,
  output logic            vma,
  output logic            vill,
  output logic [VL_W-1:0] vstart,
  output logic [1:0]      vxrm
);

  localparam logic [11:0] ADR_VSTART = 12'h008;
  localparam logic [11:0] ADR_VXSAT  = 12'h009;
  localparam logic [11:0] ADR_VXRM   = 12'h00A;
  localparam logic [11:0] ADR_VCSR   = 12'h00F;
  localparam logic [11:0] ADR_VL     = 12'hC20;
  localparam logic [11:0] ADR_VTYPE  = 12'hC21;
  localparam logic [11:0] ADR_VLENB  = 12'hC22;
  localparam logic [11:0] ADR_PERF   = 12'hCC0;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_COMMIT} state_t;

  state_t          state, state_nxt;
  logic            latch_req, dec_en, commit_en;

  logic [XLEN-1:0] avl_q;
  logic [7:0]      vt_lo_q;
  logic            vt_rsv_q;
  logic [1:0]      mode_q;
  logic [VL_W-1:0] vlmax_q;
  logic            ill_q;

  logic [VL_W-1:0] vl_q, vstart_q;
  logic            vill_q, vma_q, vta_q, vxsat_q;
  logic [2:0]      vsew_q, vlmul_q;
  logic [1:0]      vxrm_q;
  logic [XLEN-1:0] rddata_q, rd_mux, perf_rd;

  logic [2:0]      d_sew, d_lmul;
  logic [31:0]     d_base, d_vlmax;
  logic            d_ill;
  logic [VL_W-1:0] new_vl;

  logic            unused_bits;
  assign unused_bits = ^{vset_vtype[XLEN-1], csr_wrdata[XLEN-1:VL_W]};

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_req = 1'b0;
    dec_en    = 1'b0;
    commit_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (vset_req && !freeze) begin
          latch_req = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!freeze) begin
          dec_en    = 1'b1;
          state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (!freeze) begin
          commit_en = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // VLMAX = VLEN/SEW scaled by LMUL; fractional LMUL shifts right by 8-vlmul
  always_comb begin
    d_sew  = vt_lo_q[5:3];
    d_lmul = vt_lo_q[2:0];
    d_base = 32'(VLEN) >> (32'd3 + 32'(d_sew));
    if (!d_lmul[2]) d_vlmax = d_base << d_lmul[1:0];
    else            d_vlmax = d_base >> (4'd8 - {1'b0, d_lmul});
    d_ill = (d_sew > 3'd3) || ((32'd8 << d_sew) > 32'(ELEN)) ||
            (d_lmul == 3'b100) || (d_vlmax == 32'd0) || vt_rsv_q;
  end

  // avl is compared at full width so large AVLs saturate to VLMAX
  always_comb begin
    new_vl = '0;
    if (ill_q)               new_vl = '0;
    else if (mode_q == 2'b01) new_vl = vlmax_q;
    else if (mode_q == 2'b10) new_vl = (vl_q < vlmax_q) ? vl_q : vlmax_q;
    else new_vl = (avl_q < {{(XLEN-VL_W){1'b0}}, vlmax_q}) ? avl_q[VL_W-1:0] : vlmax_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avl_q    <= '0;
      vt_lo_q  <= '0;
      vt_rsv_q <= 1'b0;
      mode_q   <= '0;
      vlmax_q  <= '0;
      ill_q    <= 1'b0;
    end else begin
      if (latch_req) begin
        avl_q    <= vset_avl;
        vt_lo_q  <= vset_vtype[7:0];
        vt_rsv_q <= |vset_vtype[XLEN-2:8];
        mode_q   <= vset_mode;
      end
      if (dec_en) begin
        vlmax_q <= d_vlmax[VL_W-1:0];
        ill_q   <= d_ill;
      end
    end
  end

  // ---------------- architectural registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vl_q    <= VL_W'(RST_VL);
      vill_q  <= 1'b0;
      vma_q   <= 1'b0;
      vta_q   <= 1'b0;
      vsew_q  <= 3'b010;
      vlmul_q <= 3'b000;
    end else if (commit_en) begin
      vl_q <= new_vl;
      if (ill_q) begin
        vill_q  <= 1'b1;
        vma_q   <= 1'b0;
        vta_q   <= 1'b0;
        vsew_q  <= 3'b000;
        vlmul_q <= 3'b000;
      end else begin
        vill_q  <= 1'b0;
        vma_q   <= vt_lo_q[7];
        vta_q   <= vt_lo_q[6];
        vsew_q  <= vt_lo_q[5:3];
        vlmul_q <= vt_lo_q[2:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vstart_q <= '0;
    end else if (commit_en) begin
      vstart_q <= '0;
    end else if (vec_trap) begin
      vstart_q <= vec_trap_idx;
    end else if (vec_done) begin
      vstart_q <= '0;
    end else if (csr_wr_en && csr_adr_wr == ADR_VSTART) begin
      vstart_q <= csr_wrdata[VL_W-1:0];
    end
  end

  // a saturation event wins over a same-cycle software clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vxsat_q <= 1'b0;
      vxrm_q  <= 2'b11;
    end else begin
      if (csr_wr_en && (csr_adr_wr == ADR_VXSAT || csr_adr_wr == ADR_VCSR))
        vxsat_q <= csr_wrdata[0] | vxsat_set;
      else
        vxsat_q <= vxsat_q | vxsat_set;
      if (csr_wr_en && csr_adr_wr == ADR_VXRM) vxrm_q <= csr_wrdata[1:0];
      else if (csr_wr_en && csr_adr_wr == ADR_VCSR) vxrm_q <= csr_wrdata[2:1];
    end
  end

`ifdef VCSR_PERF_CNT_EN
  logic [31:0] perf_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           perf_cnt <= '0;
    else if (vec_done) perf_cnt <= perf_cnt + 32'd1;
  end
  assign perf_rd = XLEN'(perf_cnt);
`else
  assign perf_rd = '0;
`endif

  // ---------------- read path ----------------
  always_comb begin
    rd_mux = '0;
    case (csr_adr_rd)
      ADR_VSTART: rd_mux[VL_W-1:0] = vstart_q;
      ADR_VXSAT:  rd_mux[0]        = vxsat_q;
      ADR_VXRM:   rd_mux[1:0]      = vxrm_q;
      ADR_VCSR:   rd_mux[2:0]      = {vxrm_q, vxsat_q};
      ADR_VL:     rd_mux[VL_W-1:0] = vl_q;
      ADR_VTYPE: begin
        rd_mux[XLEN-1] = vill_q;
        rd_mux[7:0]    = {vma_q, vta_q, vsew_q, vlmul_q};
      end
      ADR_VLENB:  rd_mux = XLEN'(VLEN / 8);
      ADR_PERF:   rd_mux = perf_rd;
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rddata_q <= '0;
    else if (!freeze) rddata_q <= rd_mux;
  end

  assign csr_rddata = rddata_q;
  assign vset_busy  = (state != S_IDLE);
  assign vset_ack   = commit_en;
  assign vset_vl    = new_vl;
  assign vl         = vl_q;
  assign vsew       = vsew_q;
  assign vlmul      = vlmul_q;
  assign vta        = vta_q;
  assign vma        = vma_q;
  assign vill       = vill_q;
  assign vstart     = vstart_q;
  assign vxrm       = vxrm_q;

endmodule

// File: tb/tb_vec_csr_unit.sv
// Scoreboard bench for vec_csr_unit: stimulus pushes expected read data / ack results,
// a monitor pops and compares when read data or vset_ack is presented.
module tb_vec_csr_unit;
  localparam int XLEN = 32;
  localparam int VL_W = 9;
`ifdef VCSR_PERF_CNT_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [11:0]     csr_adr_wr = '0, csr_adr_rd = '0;
  logic [XLEN-1:0] csr_wrdata = '0, csr_rddata;
  logic            csr_wr_en = 1'b0, freeze = 1'b0;
  logic            vset_req = 1'b0;
  logic [XLEN-1:0] vset_avl = '0, vset_vtype = '0;
  logic [1:0]      vset_mode = '0;
  logic            vset_busy, vset_ack;
  logic [VL_W-1:0] vset_vl;
  logic            vxsat_set = 1'b0, vec_trap = 1'b0, vec_done = 1'b0;
  logic [VL_W-1:0] vec_trap_idx = '0;
  logic [VL_W-1:0] vl, vstart;
  logic [2:0]      vsew, vlmul;
  logic            vta, vma, vill;
  logic [1:0]      vxrm;

  vec_csr_unit #(.XLEN(32), .VLEN(256), .ELEN(32), .VL_W(9), .RST_VL(8)) dut (
    .clk(clk), .rst(rst),
    .csr_adr_wr(csr_adr_wr), .csr_wrdata(csr_wrdata), .csr_wr_en(csr_wr_en),
    .csr_adr_rd(csr_adr_rd), .csr_rddata(csr_rddata), .freeze(freeze),
    .vset_req(vset_req), .vset_avl(vset_avl), .vset_vtype(vset_vtype), .vset_mode(vset_mode),
    .vset_busy(vset_busy), .vset_ack(vset_ack), .vset_vl(vset_vl),
    .vxsat_set(vxsat_set), .vec_trap(vec_trap), .vec_trap_idx(vec_trap_idx), .vec_done(vec_done),
    .vl(vl), .vsew(vsew), .vlmul(vlmul), .vta(vta), .vma(vma), .vill(vill),
    .vstart(vstart), .vxrm(vxrm)
  );

  always #5 clk = ~clk;

  typedef struct { logic [VL_W-1:0] vl; int cyc; } ack_exp_t;
  typedef struct { logic [XLEN-1:0] data; string name; } rd_exp_t;
  ack_exp_t ack_q[$];
  rd_exp_t  rd_q[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic rd_issue = 1'b0;
  logic rd_vld   = 1'b0;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= rd_issue;
  end

  // monitor
  always @(negedge clk) begin
    if (vset_ack) begin
      n_tests++;
      if (ack_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: ack seen at cycle %0d with vl=%0d, none required", cyc, vset_vl);
      end else begin
        ack_exp_t e;
        e = ack_q.pop_front();
        if (vset_vl !== e.vl) begin
          n_fail++;
          $display("FAIL ack_vl: got %0d, required %0d", vset_vl, e.vl);
        end
        n_tests++;
        if (cyc != e.cyc) begin
          n_fail++;
          $display("FAIL ack_latency: ack at cycle %0d, required cycle %0d", cyc, e.cyc);
        end
      end
    end
    if (rd_vld) begin
      n_tests++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_underflow: data 0x%08h with no expected entry", csr_rddata);
      end else begin
        rd_exp_t r;
        r = rd_q.pop_front();
        if (csr_rddata !== r.data) begin
          n_fail++;
          $display("FAIL %s: got 0x%08h, required 0x%08h", r.name, csr_rddata, r.data);
        end
      end
    end
  end

  task automatic rd(input logic [11:0] a, input logic [XLEN-1:0] e, input string nm);
    @(posedge clk); #1;
    csr_adr_rd = a;
    rd_issue   = 1'b1;
    rd_q.push_back('{e, nm});
    @(posedge clk); #1;
    rd_issue = 1'b0;
  endtask

  task automatic rd_frozen(input logic [11:0] a, input logic [XLEN-1:0] e, input string nm);
    @(posedge clk); #1;
    csr_adr_rd = a;
    freeze     = 1'b1;
    rd_issue   = 1'b1;
    rd_q.push_back('{e, nm});
    @(posedge clk); #1;
    rd_issue = 1'b0;
    freeze   = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [XLEN-1:0] d, input logic sat);
    @(posedge clk); #1;
    csr_adr_wr = a;
    csr_wrdata = d;
    csr_wr_en  = 1'b1;
    vxsat_set  = sat;
    @(posedge clk); #1;
    csr_wr_en = 1'b0;
    vxsat_set = 1'b0;
  endtask

  task automatic trap(input logic [VL_W-1:0] idx);
    @(posedge clk); #1;
    vec_trap = 1'b1; vec_trap_idx = idx;
    @(posedge clk); #1;
    vec_trap = 1'b0;
  endtask

  task automatic done_pulse();
    @(posedge clk); #1;
    vec_done = 1'b1;
    @(posedge clk); #1;
    vec_done = 1'b0;
  endtask

  task automatic vset_start(input logic [XLEN-1:0] avl, input logic [XLEN-1:0] vt,
                            input logic [1:0] mode, input logic [VL_W-1:0] exp_vl,
                            input bit push, input int extra);
    @(posedge clk); #1;
    vset_avl = avl; vset_vtype = vt; vset_mode = mode; vset_req = 1'b1;
    if (push) ack_q.push_back('{exp_vl, cyc + 2 + extra});
    @(posedge clk); #1;
    vset_req = 1'b0;
  endtask

  task automatic vset(input logic [XLEN-1:0] avl, input logic [XLEN-1:0] vt,
                      input logic [1:0] mode, input logic [VL_W-1:0] exp_vl);
    vset_start(avl, vt, mode, exp_vl, 1'b1, 0);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    rd(12'hC20, 32'd8,    "rst_vl");
    rd(12'hC21, 32'h10,   "rst_vtype");
    rd(12'hC22, 32'd32,   "vlenb");
    rd_frozen(12'h008, 32'd32, "freeze_hold");
    rd(12'h008, 32'd0,    "rst_vstart");
    rd(12'h009, 32'd0,    "rst_vxsat");
    rd(12'h00A, 32'd3,    "rst_vxrm");
    rd(12'h00F, 32'd6,    "rst_vcsr");
    rd(12'h123, 32'd0,    "unmapped");
    rd(12'hCC0, 32'd0,    "rst_perf");

    vset(32'd100, 32'h10, 2'b00, 9'd8);
    rd(12'hC20, 32'd8,    "vl_e32m1");
    vset(32'd0, 32'h03, 2'b01, 9'd256);
    rd(12'hC20, 32'd256,  "vl_e8m8_max");
    rd(12'hC21, 32'h03,   "vtype_e8m8");
    vset(32'd0, 32'h10, 2'b10, 9'd8);
    rd(12'hC20, 32'd8,    "vl_keep_clip");
    vset(32'd100, 32'h18, 2'b00, 9'd0);
    rd(12'hC21, 32'h80000000, "vtype_ill_sew");
    rd(12'hC20, 32'd0,    "vl_ill_sew");
    vset(32'd100, 32'h14, 2'b00, 9'd0);
    rd(12'hC21, 32'h80000000, "vtype_ill_lmul");
    vset(32'd100, 32'h110, 2'b00, 9'd0);
    rd(12'hC21, 32'h80000000, "vtype_ill_rsv");
    vset(32'd3, 32'h17, 2'b00, 9'd3);
    rd(12'hC21, 32'h17,   "vtype_mf2");
    vset(32'd9, 32'h17, 2'b00, 9'd4);
    rd(12'hC20, 32'd4,    "vl_mf2_clip");
    vset(32'h80000004, 32'hD0, 2'b00, 9'd8);
    rd(12'hC21, 32'hD0,   "vtype_vma_vta");
    rd(12'hC20, 32'd8,    "vl_big_avl");

    wr(12'h00F, 32'h4, 1'b1);
    rd(12'h00A, 32'd2,    "vcsr_vxrm");
    rd(12'h009, 32'd1,    "vxsat_set_wins");
    rd(12'h00F, 32'd5,    "vcsr_rd");
    wr(12'h009, 32'h0, 1'b0);
    rd(12'h009, 32'd0,    "vxsat_clear");
    wr(12'h00A, 32'h1, 1'b0);
    rd(12'h00F, 32'd2,    "vxrm_write");
    wr(12'hC20, 32'h55, 1'b0);
    wr(12'hC21, 32'h0, 1'b0);
    rd(12'hC20, 32'd8,    "vl_readonly");
    rd(12'hC21, 32'hD0,   "vtype_readonly");

    trap(9'd5);
    rd(12'h008, 32'd5,    "vstart_trap");
    vset(32'd7, 32'h10, 2'b00, 9'd7);
    rd(12'h008, 32'd0,    "vstart_ack_clr");
    wr(12'h008, 32'h12345, 1'b0);
    rd(12'h008, 32'h145,  "vstart_write");
    done_pulse();
    rd(12'h008, 32'd0,    "vstart_done_clr");
    rd(12'hCC0, (PERF_ON != 0) ? 32'd1 : 32'd0, "perf_one");

    vset_start(32'd5, 32'h10, 2'b00, 9'd5, 1'b1, 3);
    freeze = 1'b1;
    repeat (3) @(posedge clk);
    #1 freeze = 1'b0;
    repeat (3) @(posedge clk);
    rd(12'hC20, 32'd5,    "vl_after_freeze");

    vset_start(32'd3, 32'h11, 2'b00, 9'd3, 1'b0, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    rd(12'hC20, 32'd8,    "vl_rst_commit");
    rd(12'hC21, 32'h10,   "vtype_rst_commit");
    done_pulse();
    done_pulse();
    rd(12'hCC0, (PERF_ON != 0) ? 32'd2 : 32'd0, "perf_two");

    repeat (4) @(posedge clk);
    n_tests++;
    if (ack_q.size() != 0) begin
      n_fail++;
      $display("FAIL ack_pending: %0d acks outstanding, required 0", ack_q.size());
    end
    n_tests++;
    if (rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL rd_pending: %0d reads outstanding, required 0", rd_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
